// File: rtl/jtag_tdo_mux_reg_if.sv
// TAP-side signal bundle for the JTAG TDO output stage.
// The master side is the TAP controller / register bank; the slave side is the output stage.
interface jtag_tdo_mux_reg_if #(
    parameter int NUM_DR = 3,
    parameter int CODE_W = 2,
    parameter int CNT_W  = 8
);
    logic [CODE_W-1:0] CODE;
    logic              UPDATE_IR;
    logic              SHIFT_IR;
    logic              SHIFT_DR;
    logic              IR_TDO;
    logic [NUM_DR-1:0] DR_TDO;
    logic              TDO;
    logic              TDO_EN;
    logic [CODE_W-1:0] SEL_CODE;
    logic [CNT_W-1:0]  SHIFT_CNT;
    logic              ERR;

    modport master (
        output CODE, UPDATE_IR, SHIFT_IR, SHIFT_DR, IR_TDO, DR_TDO,
        input  TDO, TDO_EN, SEL_CODE, SHIFT_CNT, ERR
    );

    modport slave (
        input  CODE, UPDATE_IR, SHIFT_IR, SHIFT_DR, IR_TDO, DR_TDO,
        output TDO, TDO_EN, SEL_CODE, SHIFT_CNT, ERR
    );
endinterface

// File: rtl/jtag_tdo_mux_reg.sv
// JTAG TDO output stage: registered TDO/TDO_EN on falling TCK, private instruction copy,
// saturating shift-bit counter and sticky SHIFT_IR/SHIFT_DR collision flag.
module jtag_tdo_mux_reg #(
    parameter int NUM_DR     = 3,
    parameter int CODE_W     = 2,
    parameter int BYPASS_IDX = 0,
    parameter int RESET_CODE = 2,
    parameter int CNT_W      = 8
) (
    input logic              TCK,
    input logic              RST,
    jtag_tdo_mux_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CODE_W-1:0] sel_code;
    logic              tdo_q;
    logic              tdo_en_q;
    logic [CNT_W-1:0]  shift_cnt;
    logic              err_q;
    logic              dr_bit;
    logic              shifting;

    // Codes with no matching channel fall through to the bypass channel.
    always_comb begin
        dr_bit = bus.DR_TDO[BYPASS_IDX];
        for (int i = 0; i < NUM_DR; i++) begin
            if (int'(sel_code) == i) begin
                dr_bit = bus.DR_TDO[i];
            end
        end
    end

    assign shifting = bus.SHIFT_IR | bus.SHIFT_DR;

    always_ff @(negedge TCK or posedge RST) begin
        if (RST) begin
            sel_code  <= CODE_W'(RESET_CODE);
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
            shift_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (bus.UPDATE_IR) begin
                sel_code <= bus.CODE;
            end

            // dr_bit is built from sel_code before this edge's load.
            if (bus.SHIFT_IR) begin
                tdo_q    <= bus.IR_TDO;
                tdo_en_q <= 1'b1;
            end else if (bus.SHIFT_DR) begin
                tdo_q    <= dr_bit;
                tdo_en_q <= 1'b1;
            end else begin
                tdo_q    <= 1'b0;
                tdo_en_q <= 1'b0;
            end

            if (!shifting) begin
                shift_cnt <= '0;
            end else if (shift_cnt != CNT_MAX) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
            end

            if (bus.SHIFT_IR && bus.SHIFT_DR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.TDO       = tdo_q;
    assign bus.TDO_EN    = tdo_en_q;
    assign bus.SEL_CODE  = sel_code;
    assign bus.SHIFT_CNT = shift_cnt;
    assign bus.ERR       = err_q;
endmodule

// File: tb/tb_jtag_tdo_mux_reg.sv
// Bench for jtag_tdo_mux_reg: directed scenarios followed by random TAP activity,
// all outputs compared against a behavioural model after every falling TCK edge.
module tb_jtag_tdo_mux_reg;
    localparam int NUM_DR     = 3;
    localparam int CODE_W     = 2;
    localparam int BYPASS_IDX = 0;
    localparam int RESET_CODE = 2;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic TCK = 1'b0;
    logic RST = 1'b0;

    jtag_tdo_mux_reg_if #(.NUM_DR(NUM_DR), .CODE_W(CODE_W), .CNT_W(CNT_W)) bus_if ();

    jtag_tdo_mux_reg #(
        .NUM_DR(NUM_DR), .CODE_W(CODE_W), .BYPASS_IDX(BYPASS_IDX),
        .RESET_CODE(RESET_CODE), .CNT_W(CNT_W)
    ) dut (
        .TCK(TCK),
        .RST(RST),
        .bus(bus_if.slave)
    );

    int total  = 0;
    int passed = 0;

    // Behavioural model state
    int m_sel, m_tdo, m_en, m_cnt, m_err;

    task automatic model_reset();
        m_sel = RESET_CODE; m_tdo = 0; m_en = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int ch;
        int sir, sdr;
        sir = int'(bus_if.SHIFT_IR);
        sdr = int'(bus_if.SHIFT_DR);
        ch  = (m_sel < NUM_DR) ? m_sel : BYPASS_IDX;
        if (sir == 1) begin
            m_tdo = int'(bus_if.IR_TDO); m_en = 1;
        end else if (sdr == 1) begin
            m_tdo = int'((bus_if.DR_TDO >> ch) & 1); m_en = 1;
        end else begin
            m_tdo = 0; m_en = 0;
        end
        if (sir + sdr > 0) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        else               m_cnt = 0;
        if (sir + sdr == 2) m_err = 1;
        if (bus_if.UPDATE_IR) m_sel = int'(bus_if.CODE);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tdo"},    int'(bus_if.TDO),       m_tdo);
        check({tag, ".tdo_en"}, int'(bus_if.TDO_EN),    m_en);
        check({tag, ".sel"},    int'(bus_if.SEL_CODE),  m_sel);
        check({tag, ".cnt"},    int'(bus_if.SHIFT_CNT), m_cnt);
        check({tag, ".err"},    int'(bus_if.ERR),       m_err);
    endtask

    // One TCK cycle: high phase, falling (active) edge, then sample 1 time unit later.
    task automatic tick();
        #5 TCK = 1'b1;
        #5 TCK = 1'b0;
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.CODE = '0; bus_if.UPDATE_IR = 1'b0; bus_if.SHIFT_IR = 1'b0;
        bus_if.SHIFT_DR = 1'b0; bus_if.IR_TDO = 1'b0; bus_if.DR_TDO = '0;
    endtask

    task automatic load_code(input int code);
        idle_inputs();
        bus_if.CODE = CODE_W'(code);
        bus_if.UPDATE_IR = 1'b1;
        tick();
        bus_if.UPDATE_IR = 1'b0;
        check_all("load");
    endtask

    logic [3:0] pat;

    initial begin
        idle_inputs();
        // Reset with TCK stopped
        #1 RST = 1'b1;
        model_reset();
        #2;
        check("rst.tdo",    int'(bus_if.TDO),       0);
        check("rst.tdo_en", int'(bus_if.TDO_EN),    0);
        check("rst.sel",    int'(bus_if.SEL_CODE),  2);
        check("rst.cnt",    int'(bus_if.SHIFT_CNT), 0);
        check("rst.err",    int'(bus_if.ERR),       0);
        RST = 1'b0;
        #1;

        // Device-ID channel straight out of reset
        bus_if.SHIFT_DR = 1'b1; bus_if.DR_TDO = 3'b100;
        tick();
        check("idcode.tdo",    int'(bus_if.TDO),    1);
        check("idcode.tdo_en", int'(bus_if.TDO_EN), 1);
        check_all("idcode");

        // Load code 1 and shift DR channel 1
        load_code(1);
        check("sel1", int'(bus_if.SEL_CODE), 1);
        pat = 4'b1101;
        bus_if.SHIFT_DR = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus_if.DR_TDO = {1'b0, pat[i], 1'b0};
            tick();
            check("dr1.tdo", int'(bus_if.TDO), int'(pat[i]));
            check_all("dr1");
        end
        check("dr1.cnt4", int'(bus_if.SHIFT_CNT), 4);

        // Unused code falls back to bypass channel 0
        load_code(3);
        bus_if.SHIFT_DR = 1'b1; bus_if.DR_TDO = 3'b001;
        tick();
        check("byp.tdo1", int'(bus_if.TDO), 1);
        bus_if.DR_TDO = 3'b110;
        tick();
        check("byp.tdo0", int'(bus_if.TDO), 0);
        check_all("byp");

        // IR shift while a DR instruction is active
        load_code(1);
        bus_if.SHIFT_IR = 1'b1; bus_if.IR_TDO = 1'b0; bus_if.DR_TDO = 3'b111;
        tick();
        check("ir.tdo0", int'(bus_if.TDO), 0);
        check("ir.en0",  int'(bus_if.TDO_EN), 1);
        bus_if.IR_TDO = 1'b1;
        tick();
        check("ir.tdo1", int'(bus_if.TDO), 1);
        bus_if.SHIFT_IR = 1'b0;
        tick();
        check("ir.off.tdo", int'(bus_if.TDO), 0);
        check("ir.off.en",  int'(bus_if.TDO_EN), 0);
        check("ir.off.cnt", int'(bus_if.SHIFT_CNT), 0);

        // Counter saturation
        bus_if.SHIFT_DR = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            bus_if.DR_TDO = NUM_DR'($urandom);
            tick();
            check("sat.cnt", int'(bus_if.SHIFT_CNT), (i > 255) ? 255 : i);
        end
        bus_if.SHIFT_DR = 1'b0;
        tick();
        check("sat.clr", int'(bus_if.SHIFT_CNT), 0);

        // Protocol error, then async reset mid-shift
        bus_if.SHIFT_IR = 1'b1; bus_if.SHIFT_DR = 1'b1;
        bus_if.IR_TDO = 1'b1; bus_if.DR_TDO = 3'b000;
        tick();
        check("err.tdo", int'(bus_if.TDO), 1);
        check("err.set", int'(bus_if.ERR), 1);
        bus_if.SHIFT_IR = 1'b0; bus_if.SHIFT_DR = 1'b0;
        tick();
        check("err.sticky", int'(bus_if.ERR), 1);
        bus_if.SHIFT_DR = 1'b1; bus_if.DR_TDO = 3'b111;
        tick();
        tick();
        #2 RST = 1'b1;
        model_reset();
        #1;
        check("arst.err",    int'(bus_if.ERR),       0);
        check("arst.tdo_en", int'(bus_if.TDO_EN),    0);
        check("arst.tdo",    int'(bus_if.TDO),       0);
        check("arst.cnt",    int'(bus_if.SHIFT_CNT), 0);
        check("arst.sel",    int'(bus_if.SEL_CODE),  RESET_CODE);
        RST = 1'b0;
        tick();
        check_all("arst.first");

        // Random TAP activity, including illegal combinations and occasional resets
        for (int n = 0; n < 600; n++) begin
            bus_if.CODE      = CODE_W'($urandom);
            bus_if.UPDATE_IR = ($urandom_range(0, 7) == 0);
            bus_if.SHIFT_IR  = ($urandom_range(0, 3) == 0);
            bus_if.SHIFT_DR  = ($urandom_range(0, 1) == 0);
            bus_if.IR_TDO    = 1'($urandom);
            bus_if.DR_TDO    = NUM_DR'($urandom);
            tick();
            check_all("rand");
            if ($urandom_range(0, 59) == 0) begin
                #1 RST = 1'b1;
                model_reset();
                #1;
                check_all("rand.rst");
                RST = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
